// File: rtl/edge_detect_multi.sv
// Multi-channel edge detector: per-channel synchroniser and debouncer,
// mode-qualified one-cycle edge pulses, sticky flags, a summary interrupt
// and a saturating event counter. Every output is registered.
module edge_detect_multi #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   din,
    input  logic [2*WIDTH-1:0] mode,
    input  logic [WIDTH-1:0]   irq_en,
    input  logic [WIDTH-1:0]   clr_sticky,
    input  logic               cnt_clr,
    output logic [WIDTH-1:0]   level,
    output logic [WIDTH-1:0]   pulse,
    output logic [WIDTH-1:0]   sticky,
    output logic               irq,
    output logic [CNT_W-1:0]   ev_count
);

    localparam int DCNT_W = $clog2(DEB_CYCLES + 1);
    localparam int SUM_W  = CNT_W + $clog2(WIDTH + 1) + 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } deb_state_t;

    // Does a flip to new_lvl count as an event under channel mode m?
    function automatic logic qualify(input logic [1:0] m, input logic new_lvl);
        case (m)
            2'b00:   return new_lvl;
            2'b01:   return ~new_lvl;
            2'b10:   return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [SUM_W-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int k = 0; k < WIDTH; k++) begin
            n = n + SUM_W'(v[k]);
        end
        return n;
    endfunction

    // Add without wrapping: clamps at the all-ones counter value.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] base,
                                                 input logic [SUM_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        sum = SUM_W'(base) + inc;
        if (sum > SUM_W'(CNT_MAX)) begin
            return CNT_MAX;
        end
        return sum[CNT_W-1:0];
    endfunction

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0]  sync_s;
    deb_state_t        state_q [WIDTH];
    deb_state_t        state_d [WIDTH];
    logic [DCNT_W-1:0] dcnt_q  [WIDTH];
    logic [DCNT_W-1:0] dcnt_d  [WIDTH];
    logic [WIDTH-1:0]  flip_d;
    logic [WIDTH-1:0]  level_q, level_d;
    logic [WIDTH-1:0]  pulse_q, pulse_d;
    logic [WIDTH-1:0]  sticky_q, sticky_d;
    logic              irq_q, irq_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: stage 0 samples the raw async inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    // Debounce FSM per channel; a level flip is qualified by the current mode.
    always_comb begin
        level_d = level_q;
        pulse_d = '0;
        flip_d  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            dcnt_d[i]  = dcnt_q[i];
            case (state_q[i])
                ST_STABLE: begin
                    if (sync_s[i] != level_q[i]) begin
                        if (DEB_CYCLES == 1) begin
                            flip_d[i] = 1'b1;
                            dcnt_d[i] = '0;
                        end else begin
                            state_d[i] = ST_CHANGING;
                            dcnt_d[i]  = DCNT_W'(1);
                        end
                    end else begin
                        dcnt_d[i] = '0;
                    end
                end
                ST_CHANGING: begin
                    if (sync_s[i] == level_q[i]) begin
                        state_d[i] = ST_STABLE;
                        dcnt_d[i]  = '0;
                    end else if (dcnt_q[i] == DCNT_LAST) begin
                        flip_d[i]  = 1'b1;
                        state_d[i] = ST_STABLE;
                        dcnt_d[i]  = '0;
                    end else begin
                        dcnt_d[i] = dcnt_q[i] + DCNT_W'(1);
                    end
                end
                default: begin
                    state_d[i] = ST_STABLE;
                    dcnt_d[i]  = '0;
                end
            endcase
            if (flip_d[i]) begin
                level_d[i] = sync_s[i];
                pulse_d[i] = qualify(mode[2*i +: 2], sync_s[i]);
            end
        end
    end

    // Sticky set beats clear; irq and counter follow the next-state values.
    always_comb begin
        sticky_d = (sticky_q & ~clr_sticky) | pulse_d;
        irq_d    = |(sticky_d & irq_en);
        cnt_d    = sat_add(cnt_clr ? '0 : cnt_q, popcount(pulse_d));
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= ST_STABLE;
                dcnt_q[i]  <= '0;
            end
            level_q  <= '0;
            pulse_q  <= '0;
            sticky_q <= '0;
            irq_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            level_q  <= level_d;
            pulse_q  <= pulse_d;
            sticky_q <= sticky_d;
            irq_q    <= irq_d;
            cnt_q    <= cnt_d;
        end
    end

    assign level    = level_q;
    assign pulse    = pulse_q;
    assign sticky   = sticky_q;
    assign irq      = irq_q;
    assign ev_count = cnt_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// Bench for edge_detect_multi: directed scenarios plus random stimulus,
// checked every cycle against a window-based behavioural model.
module tb_edge_detect_multi;

    localparam int W    = 8;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic            clk;
    logic            rst;
    logic [W-1:0]    din;
    logic [2*W-1:0]  mode;
    logic [W-1:0]    irq_en;
    logic [W-1:0]    clr_sticky;
    logic            cnt_clr;
    logic [W-1:0]    level;
    logic [W-1:0]    pulse;
    logic [W-1:0]    sticky;
    logic            irq;
    logic [CW-1:0]   ev_count;

    edge_detect_multi #(
        .WIDTH(W), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .din(din), .mode(mode), .irq_en(irq_en),
        .clr_sticky(clr_sticky), .cnt_clr(cnt_clr), .level(level),
        .pulse(pulse), .sticky(sticky), .irq(irq), .ev_count(ev_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model state
    logic [W-1:0] dh [SYNC];   // din samples still travelling through the synchroniser
    logic [W-1:0] sh [DEB];    // most recent synchronised samples, [0] newest
    logic [W-1:0] m_level, m_pulse, m_sticky;
    logic         m_irq;
    int           m_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at that edge,
    // then compare every output.
    task automatic tick();
        logic [W-1:0] s_now;
        logic [W-1:0] pn;
        logic         flip;
        int           pc;
        @(posedge clk);
        cyc++;
        if (rst) begin
            for (int k = 0; k < SYNC; k++) dh[k] = '0;
            for (int k = 0; k < DEB; k++) sh[k] = '0;
            m_level = '0; m_pulse = '0; m_sticky = '0; m_irq = 1'b0; m_cnt = 0;
        end else begin
            s_now = dh[SYNC-1];
            for (int k = SYNC-1; k > 0; k--) dh[k] = dh[k-1];
            dh[0] = din;
            for (int k = DEB-1; k > 0; k--) sh[k] = sh[k-1];
            sh[0] = s_now;
            pn = '0;
            for (int i = 0; i < W; i++) begin
                // A level flips once the last DEB synchronised samples all disagree with it.
                flip = 1'b1;
                for (int k = 0; k < DEB; k++) if (sh[k][i] == m_level[i]) flip = 1'b0;
                if (flip) begin
                    m_level[i] = ~m_level[i];
                    case (mode[2*i +: 2])
                        2'b00:   pn[i] = m_level[i];
                        2'b01:   pn[i] = ~m_level[i];
                        2'b10:   pn[i] = 1'b1;
                        default: pn[i] = 1'b0;
                    endcase
                end
            end
            m_pulse  = pn;
            m_sticky = (m_sticky & ~clr_sticky) | pn;
            m_irq    = |(m_sticky & irq_en);
            pc = (cnt_clr ? 0 : m_cnt) + $countones(pn);
            m_cnt = (pc > CMAX) ? CMAX : pc;
        end
        #1;
        chk("level",    32'(level),    32'(m_level));
        chk("pulse",    32'(pulse),    32'(m_pulse));
        chk("sticky",   32'(sticky),   32'(m_sticky));
        chk("irq",      32'(irq),      32'(m_irq));
        chk("ev_count", 32'(ev_count), 32'(m_cnt));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        rst = 1'b1; din = '0; mode = '0; irq_en = '0; clr_sticky = '0; cnt_clr = 1'b0;
        for (int k = 0; k < SYNC; k++) dh[k] = '0;
        for (int k = 0; k < DEB; k++) sh[k] = '0;
        m_level = '0; m_pulse = '0; m_sticky = '0; m_irq = 1'b0; m_cnt = 0;

        ticks(2);
        chk("rst_level", 32'(level), 0);
        chk("rst_count", 32'(ev_count), 0);
        rst = 1'b0;
        ticks(3);

        // 1: rising edge on ch0, level and pulse 5 edges after capture
        din[0] = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t1_level_early", 32'(level[0]), 0);
        end
        tick();
        chk("t1_level", 32'(level[0]), 1);
        chk("t1_pulse", 32'(pulse[0]), 1);
        chk("t1_sticky", 32'(sticky[0]), 1);
        chk("t1_count", 32'(ev_count), 1);
        tick();
        chk("t1_pulse_end", 32'(pulse[0]), 0);

        // 2: 3-cycle glitch on ch1 is rejected
        din[1] = 1'b1;
        ticks(3);
        din[1] = 1'b0;
        ticks(10);
        chk("t2_level", 32'(level[1]), 0);
        chk("t2_count", 32'(ev_count), 1);

        // 3: ch2 both-edges, then off
        mode[5:4] = 2'b10;
        din[2] = 1'b1; ticks(10);
        din[2] = 1'b0; ticks(10);
        chk("t3_both_count", 32'(ev_count), 3);
        mode[5:4] = 2'b11;
        din[2] = 1'b1; ticks(10);
        chk("t3_off_level", 32'(level[2]), 1);
        din[2] = 1'b0; ticks(10);
        chk("t3_off_count", 32'(ev_count), 3);

        // 4: sticky / irq on ch3, clear coincident with a new pulse
        irq_en[3] = 1'b1;
        din[3] = 1'b1; ticks(10);
        chk("t4_sticky", 32'(sticky[3]), 1);
        chk("t4_irq", 32'(irq), 1);
        mode[7:6] = 2'b10;
        din[3] = 1'b0;
        ticks(5);
        clr_sticky[3] = 1'b1;
        tick();
        chk("t4_pulse", 32'(pulse[3]), 1);
        chk("t4_set_wins", 32'(sticky[3]), 1);
        tick();
        chk("t4_cleared", 32'(sticky[3]), 0);
        chk("t4_irq_low", 32'(irq), 0);
        clr_sticky[3] = 1'b0;
        chk("t4_count", 32'(ev_count), 5);

        // 5: saturation with all 8 channels, then clear-and-add
        mode = {W{2'b10}};
        din = ~din; ticks(10);
        chk("t5_count_13", 32'(ev_count), 13);
        din = ~din; ticks(10);
        chk("t5_saturate", 32'(ev_count), CMAX);
        din[1:0] = ~din[1:0];
        ticks(5);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("t5_clr_add", 32'(ev_count), 2);
        ticks(2);

        // 6: reset mid-debounce, din held high across release
        mode = '0;
        din = '0; ticks(10);
        din[4] = 1'b1;
        ticks(4);
        rst = 1'b1;
        tick();
        chk("t6_rst_level", 32'(level), 0);
        chk("t6_rst_sticky", 32'(sticky), 0);
        chk("t6_rst_count", 32'(ev_count), 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t6_pulse_early", 32'(pulse[4]), 0);
        end
        tick();
        chk("t6_pulse", 32'(pulse[4]), 1);
        chk("t6_count", 32'(ev_count), 1);

        // Random phase: mostly-held inputs with sparse controls
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < W; i++) if ($urandom_range(7) == 0) din[i] = ~din[i];
            if ($urandom_range(31) == 0) mode = 16'($urandom);
            if ($urandom_range(15) == 0) irq_en = 8'($urandom);
            clr_sticky = ($urandom_range(7) == 0) ? 8'($urandom) : '0;
            cnt_clr = ($urandom_range(19) == 0);
            rst = ($urandom_range(149) == 0);
            tick();
        end
        rst = 1'b0; cnt_clr = 1'b0; clr_sticky = '0;
        ticks(2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
